// File: rtl/menu_controller_n.sv
// menu_controller_n
// Front-panel menu controller. Each of NUM_FIELDS buttons steps its own menu
// field through 0..FIELD_MAX[i] with wrap-around. Each button has its own
// synchroniser, rising-edge detector and hold-to-auto-repeat FSM. There are
// also global direction, lock and bulk-load controls.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-high reset
//   btn_i      - raw button levels, one per field, asynchronous to clk
//   dir_i      - 0 = increment, 1 = decrement (sampled on the step cycle)
//   lock_i     - 1 = drop all button steps (the repeat FSMs keep running)
//   cfg_load_i - one-cycle pulse: load cfg_data_i (saturated) into all fields
//   cfg_data_i - packed load values, slice i = field i
//   field_o    - packed current field values, slice i = field i
//   changed_o  - one-cycle pulse per field, aligned with its new value
module menu_controller_n #(
  parameter int                            NUM_FIELDS    = 4,
  parameter int                            FIELD_W       = 3,
  parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_MAX     = 12'h852,
  parameter int                            REPEAT_DELAY  = 50_000_000,
  parameter int                            REPEAT_PERIOD = 12_500_000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_FIELDS-1:0]         btn_i,
  input  logic                          dir_i,
  input  logic                          lock_i,
  input  logic                          cfg_load_i,
  input  logic [NUM_FIELDS*FIELD_W-1:0] cfg_data_i,
  output logic [NUM_FIELDS*FIELD_W-1:0] field_o,
  output logic [NUM_FIELDS-1:0]         changed_o
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

  logic [NUM_FIELDS-1:0]         s1_r, s2_r, p_r;
  logic [NUM_FIELDS-1:0]         raw_s, step_s;
  rep_state_t                    state_r [NUM_FIELDS];
  rep_state_t                    state_s [NUM_FIELDS];
  logic [CNT_W-1:0]              cnt_r   [NUM_FIELDS];
  logic [CNT_W-1:0]              cnt_s   [NUM_FIELDS];
  logic [NUM_FIELDS*FIELD_W-1:0] field_r, field_s;
  logic [NUM_FIELDS-1:0]         changed_r, changed_s;

  // Next value of one field: a load (saturated to mx) wins over a step.
  function automatic logic [FIELD_W-1:0] field_next(
    input logic [FIELD_W-1:0] cur,
    input logic [FIELD_W-1:0] mx,
    input logic [FIELD_W-1:0] ld,
    input logic               load,
    input logic               step,
    input logic               dir
  );
    logic [FIELD_W-1:0] nxt;
    if (load) begin
      nxt = (ld > mx) ? mx : ld;
    end else if (step) begin
      if (dir) begin
        nxt = (cur == '0) ? mx : (cur - FIELD_W'(1'b1));
      end else begin
        nxt = (cur == mx) ? '0 : (cur + FIELD_W'(1'b1));
      end
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

  assign raw_s = s2_r & ~p_r;

  // Synchroniser and edge register. All three reset to 1: the button is treated
  // as already held, so a button held across reset cannot produce an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_r <= '1;
      s2_r <= '1;
      p_r  <= '1;
    end else begin
      s1_r <= btn_i;
      s2_r <= s1_r;
      p_r  <= s2_r;
    end
  end

  // Repeat FSM state and counter registers, one per field.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_FIELDS; i++) begin
        state_r[i] <= ST_IDLE;
        cnt_r[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FIELDS; i++) begin
        state_r[i] <= state_s[i];
        cnt_r[i]   <= cnt_s[i];
      end
    end
  end

  // Repeat FSM next state: issues the first step on the edge, then delay/period steps.
  always_comb begin
    step_s = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      state_s[i] = state_r[i];
      cnt_s[i]   = cnt_r[i];
      case (state_r[i])
        ST_IDLE: begin
          if (raw_s[i]) begin
            step_s[i]  = 1'b1;
            cnt_s[i]   = '0;
            state_s[i] = ST_HELD;
          end else begin
            state_s[i] = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (!s2_r[i]) begin
            cnt_s[i]   = '0;
            state_s[i] = ST_IDLE;
          end else if (REPEAT_DELAY == 0) begin
            // Auto-repeat disabled: wait here for the release.
            cnt_s[i] = cnt_r[i];
          end else if (cnt_r[i] == DELAY_LAST) begin
            step_s[i]  = 1'b1;
            cnt_s[i]   = '0;
            state_s[i] = ST_REPEAT;
          end else begin
            cnt_s[i] = cnt_r[i] + CNT_W'(1'b1);
          end
        end
        ST_REPEAT: begin
          if (!s2_r[i]) begin
            cnt_s[i]   = '0;
            state_s[i] = ST_IDLE;
          end else if (cnt_r[i] == PERIOD_LAST) begin
            step_s[i] = 1'b1;
            cnt_s[i]  = '0;
          end else begin
            cnt_s[i] = cnt_r[i] + CNT_W'(1'b1);
          end
        end
        default: begin
          cnt_s[i]   = '0;
          state_s[i] = ST_IDLE;
        end
      endcase
    end
  end

  // Field update: load beats steps, lock drops steps. changed_s flags any real value change.
  always_comb begin
    field_s   = '0;
    changed_s = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      field_s[i*FIELD_W +: FIELD_W] = field_next(field_r[i*FIELD_W +: FIELD_W],
                                                 FIELD_MAX[i*FIELD_W +: FIELD_W],
                                                 cfg_data_i[i*FIELD_W +: FIELD_W],
                                                 cfg_load_i,
                                                 step_s[i] & ~lock_i,
                                                 dir_i);
      changed_s[i] = (field_s[i*FIELD_W +: FIELD_W] != field_r[i*FIELD_W +: FIELD_W]);
    end
  end

  // Field and change-pulse output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      field_r   <= '0;
      changed_r <= '0;
    end else begin
      field_r   <= field_s;
      changed_r <= changed_s;
    end
  end

  assign field_o   = field_r;
  assign changed_o = changed_r;

endmodule
